sensor_scheduler: RTL and testbench
===================================

// Module: sensor_scheduler
// PURPOSE
//  Sequences the three ultrasonic sensors through one shared distance-measurement unit.
//  Each sweep runs in fixed order. For every enabled sensor it selects the sensor, pulses a start,
//  waits for the result or a timeout, stores a per-sensor result and inserts a settling gap.
//  Sits between the top-level start/mode controls and the shared measurement datapath.
//  Feeds the per-sensor distances and status flags to the valve/alarm logic and the debug displays.
// PARAMETERS
//  MEDIDA_W        12          width of a measurement (3 BCD digits)
//  TIMEOUT_CYCLES  2_000_000   max cycles waiting for med_pronto (40 ms @ 50 MHz)
//  GAP_CYCLES      3_000_000   idle cycles between consecutive measurements (60 ms)
// PORTS
//  clock          in   1         system clock, rising edge
//  reset          in   1         asynchronous, active-low reset
//  iniciar        in   1         start request; rising edge starts a sweep
//  continuo       in   1         1 = restart sweeps back-to-back
//  mascara        in   3         per-sensor enable, bit i = sensor i+1
//  med_pronto     in   1         shared unit: result valid (1-cycle pulse)
//  med_valor      in   MEDIDA_W  shared unit: measured distance
//  med_start      out  1         1-cycle start pulse to the shared unit
//  sel_sensor     out  2         sensor routed to the shared unit (0..2)
//  distancia1..3  out  MEDIDA_W  last good distance per sensor
//  valido         out  3         bit i: last attempt on sensor i+1 succeeded
//  erro_timeout   out  3         bit i: last attempt on sensor i+1 timed out
//  varredura_fim  out  1         1-cycle pulse at end of every sweep
//  ocupado        out  1         high from PREPARA through FIM
//  db_estado      out  4         FSM state code
//  db_sensor      out  4         sel_sensor+1 while ocupado, else 0
// BEHAVIOUR
//  Reset (asynchronous, active-low) clears all outputs and state to 0 and sets the FSM to INICIAL.
//    This applies mid-operation too; med_start drops immediately.
//  iniciar is registered and edge-detected. Edges outside INICIAL are ignored.
//  States (db_estado code):
//   INICIAL 0: idle. Edge on iniciar -> PREPARA.
//   PREPARA 1: latch mascara into mask_r. If mask_r==0 -> FIM.
//     Otherwise sel = lowest set bit -> DISPARA.
//   DISPARA 2: med_start=1 for exactly one cycle; clear the wait counter -> ESPERA.
//   ESPERA 3: count cycles. med_pronto -> ARMAZENA.
//     Counter reaching TIMEOUT_CYCLES-1 -> TIMEOUT.
//     If med_pronto and timeout occur in the same cycle, med_pronto wins.
//   ARMAZENA 4: distancia[sel] <= med_valor; valido[sel]=1; erro_timeout[sel]=0 -> INTERVALO.
//   TIMEOUT 5: erro_timeout[sel]=1; valido[sel]=0; distancia[sel] keeps its value -> INTERVALO.
//   INTERVALO 6: wait GAP_CYCLES cycles.
//     Then, if a higher-index bit is set in mask_r: sel = next such bit -> DISPARA.
//     Otherwise -> FIM.
//   FIM 7: varredura_fim=1 for one cycle. continuo=1 -> PREPARA; otherwise -> INICIAL.
//  med_pronto outside ESPERA is ignored.
//  Changes to mascara take effect only at the next PREPARA.
//  Clearing continuo mid-sweep lets the current sweep finish, then the FSM returns to INICIAL.
//  Latency, start of sweep:
//    iniciar edge -> med_start pulse is 3 cycles: sync, PREPARA, DISPARA.
//  Latency, between sensors:
//    med_pronto -> next med_start is GAP_CYCLES+2 cycles.
//  sel_sensor is stable from DISPARA until the next selection; it changes only in PREPARA/INTERVALO.
//  Counters are sized to hold max(TIMEOUT_CYCLES, GAP_CYCLES) and never wrap.
// TESTING (bench: TIMEOUT_CYCLES=100, GAP_CYCLES=20, model answers 10 cycles after med_start)
//  1 mascara=111, continuo=0, pulse iniciar; model returns 0x123, 0x045, 0x300
//    -> 3 med_start pulses with sel 0,1,2, spaced 10+22 cycles
//    -> distancia1..3=0x123/0x045/0x300, valido=111
//    -> one varredura_fim pulse, then INICIAL.
//  2 Model silent for sensor 2
//    -> after 100 cycles: erro_timeout=010, valido=101, distancia2 unchanged
//    -> sweep completes normally.
//  3 mascara=101 -> only sel 0 and 2 started.
//    mascara=000 -> PREPARA->FIM, varredura_fim pulses, no med_start.
//  4 continuo=1 -> PREPARA entered the cycle after FIM.
//    Drop continuo mid-sweep -> that sweep ends, FSM returns to INICIAL.
//  5 reset low in ESPERA
//    -> all outputs 0 in the same cycle.
//    -> A med_pronto arriving after reset releases is ignored.
//    -> iniciar held high across reset release starts no sweep (edge only).
//  6 med_pronto on the exact timeout cycle
//    -> ARMAZENA, valido bit set, erro bit clear.
//    iniciar edge while ocupado -> ignored.

Source files
------------

// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
// Sequences three ultrasonic sensors through one shared distance-measurement
// unit. A sweep visits each enabled sensor in index order: select it, pulse a
// start, wait for the result or a timeout, store the outcome, then hold a
// settling gap before the next sensor.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   iniciar        start request (rising edge starts a sweep from idle)
//   continuo       1 = start the next sweep right after the current one
//   mascara[2:0]   per-sensor enable, bit i = sensor i+1 (sampled in PREPARA)
//   med_pronto     shared unit result valid (1-cycle pulse)
//   med_valor      shared unit measured distance
//   med_start      1-cycle start pulse to the shared unit
//   sel_sensor     sensor currently routed to the shared unit (0..2)
//   distancia1..3  last good distance per sensor
//   valido[2:0]    last attempt on sensor i+1 succeeded
//   erro_timeout   last attempt on sensor i+1 timed out
//   varredura_fim  1-cycle pulse at the end of every sweep
//   ocupado        high from PREPARA through FIM
//   db_estado      FSM state code
//   db_sensor      sel_sensor+1 while ocupado, else 0
// -----------------------------------------------------------------------------
module sensor_scheduler #(
    parameter int MEDIDA_W       = 12,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int GAP_CYCLES     = 3_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                continuo,
    input  logic [2:0]          mascara,
    input  logic                med_pronto,
    input  logic [MEDIDA_W-1:0] med_valor,
    output logic                med_start,
    output logic [1:0]          sel_sensor,
    output logic [MEDIDA_W-1:0] distancia1,
    output logic [MEDIDA_W-1:0] distancia2,
    output logic [MEDIDA_W-1:0] distancia3,
    output logic [2:0]          valido,
    output logic [2:0]          erro_timeout,
    output logic                varredura_fim,
    output logic                ocupado,
    output logic [3:0]          db_estado,
    output logic [3:0]          db_sensor
);

    // One shared counter serves both the timeout and the gap, so it is sized
    // for the larger of the two; it is cleared before each use and never wraps.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        DISPARA   = 4'd2,
        ESPERA    = 4'd3,
        ARMAZENA  = 4'd4,
        TIMEOUT   = 4'd5,
        INTERVALO = 4'd6,
        FIM       = 4'd7
    } state_t;

    // Lowest enabled sensor; only meaningful for a non-zero mask.
    function automatic logic [1:0] first_sel(input logic [2:0] m);
        if (m[0]) begin
            return 2'd0;
        end else if (m[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // True when the mask enables a sensor above the current one.
    function automatic logic has_next(input logic [1:0] s, input logic [2:0] m);
        case (s)
            2'd0:    return m[1] | m[2];
            2'd1:    return m[2];
            default: return 1'b0;
        endcase
    endfunction

    // Next enabled sensor above s; valid only when has_next() is true.
    function automatic logic [1:0] next_sel(input logic [1:0] s, input logic [2:0] m);
        case (s)
            2'd0:    return m[1] ? 2'd1 : 2'd2;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ini_sync;
    logic                r_ini_prev;
    logic                r_ini_armed;
    logic                w_ini_edge;
    logic [2:0]          r_mask;
    logic [2:0]          w_mask_nxt;
    logic [1:0]          r_sel;
    logic [1:0]          w_sel_nxt;
    logic [2:0]          w_sel_oh;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [MEDIDA_W-1:0] r_val_cap;
    logic [MEDIDA_W-1:0] r_dist1;
    logic [MEDIDA_W-1:0] r_dist2;
    logic [MEDIDA_W-1:0] r_dist3;
    logic [2:0]          r_valido;
    logic [2:0]          r_erro;
    logic                r_med_start;
    logic                r_fim;
    logic                r_ocupado;
    logic [3:0]          r_db_sensor;

    // A level already high when reset releases must not count as an edge:
    // r_ini_armed only sets once iniciar has been seen low.
    assign w_ini_edge = r_ini_sync & ~r_ini_prev & r_ini_armed;
    assign w_sel_oh   = sel_onehot(r_sel);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= INICIAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; in ESPERA a result beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INICIAL:   w_state_nxt = w_ini_edge ? PREPARA : INICIAL;
            PREPARA:   w_state_nxt = (mascara == 3'b000) ? FIM : DISPARA;
            DISPARA:   w_state_nxt = ESPERA;
            ESPERA: begin
                if (med_pronto) begin
                    w_state_nxt = ARMAZENA;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = TIMEOUT;
                end else begin
                    w_state_nxt = ESPERA;
                end
            end
            ARMAZENA:  w_state_nxt = INTERVALO;
            TIMEOUT:   w_state_nxt = INTERVALO;
            INTERVALO: begin
                if (r_cnt != GAP_LAST) begin
                    w_state_nxt = INTERVALO;
                end else if (has_next(r_sel, r_mask)) begin
                    w_state_nxt = DISPARA;
                end else begin
                    w_state_nxt = FIM;
                end
            end
            FIM:       w_state_nxt = continuo ? PREPARA : INICIAL;
            default:   w_state_nxt = INICIAL;
        endcase
    end

    // Datapath next values: mask/selection updates and the shared counter.
    always_comb begin
        w_mask_nxt = r_mask;
        w_sel_nxt  = r_sel;
        w_cnt_nxt  = {CNT_W{1'b0}};
        case (r_state)
            PREPARA: begin
                w_mask_nxt = mascara;
                if (mascara != 3'b000) begin
                    w_sel_nxt = first_sel(mascara);
                end else begin
                    w_sel_nxt = r_sel;
                end
            end
            ESPERA: begin
                if (w_state_nxt == ESPERA) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            INTERVALO: begin
                if (w_state_nxt == INTERVALO) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (w_state_nxt == DISPARA) begin
                    w_sel_nxt = next_sel(r_sel, r_mask);
                end else begin
                    w_sel_nxt = r_sel;
                end
            end
            default: begin
                w_cnt_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // Start-request sampling, sequencing registers and per-sensor results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ini_sync  <= 1'b0;
            r_ini_prev  <= 1'b0;
            r_ini_armed <= 1'b0;
            r_mask      <= 3'b000;
            r_sel       <= 2'd0;
            r_cnt       <= {CNT_W{1'b0}};
            r_val_cap   <= {MEDIDA_W{1'b0}};
            r_dist1     <= {MEDIDA_W{1'b0}};
            r_dist2     <= {MEDIDA_W{1'b0}};
            r_dist3     <= {MEDIDA_W{1'b0}};
            r_valido    <= 3'b000;
            r_erro      <= 3'b000;
        end else begin
            r_ini_sync  <= iniciar;
            r_ini_prev  <= r_ini_sync;
            r_ini_armed <= r_ini_armed | ~iniciar;
            r_mask      <= w_mask_nxt;
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            // The value is captured with its valid pulse so it cannot drift
            // before ARMAZENA commits it.
            if (r_state == ESPERA && med_pronto) begin
                r_val_cap <= med_valor;
            end
            case (r_state)
                ARMAZENA: begin
                    if (w_sel_oh[0]) r_dist1 <= r_val_cap;
                    if (w_sel_oh[1]) r_dist2 <= r_val_cap;
                    if (w_sel_oh[2]) r_dist3 <= r_val_cap;
                    r_valido <= r_valido | w_sel_oh;
                    r_erro   <= r_erro & ~w_sel_oh;
                end
                TIMEOUT: begin
                    r_valido <= r_valido & ~w_sel_oh;
                    r_erro   <= r_erro | w_sel_oh;
                end
                default: begin
                    r_valido <= r_valido;
                    r_erro   <= r_erro;
                end
            endcase
        end
    end

    // Output registers, decoded from the upcoming state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_med_start <= 1'b0;
            r_fim       <= 1'b0;
            r_ocupado   <= 1'b0;
            r_db_sensor <= 4'd0;
        end else begin
            r_med_start <= (w_state_nxt == DISPARA);
            r_fim       <= (w_state_nxt == FIM);
            r_ocupado   <= (w_state_nxt != INICIAL);
            r_db_sensor <= (w_state_nxt != INICIAL) ? ({2'b00, w_sel_nxt} + 4'd1) : 4'd0;
        end
    end

    assign med_start     = r_med_start;
    assign sel_sensor    = r_sel;
    assign distancia1    = r_dist1;
    assign distancia2    = r_dist2;
    assign distancia3    = r_dist3;
    assign valido        = r_valido;
    assign erro_timeout  = r_erro;
    assign varredura_fim = r_fim;
    assign ocupado       = r_ocupado;
    assign db_estado     = r_state;
    assign db_sensor     = r_db_sensor;

endmodule

// File: tb/tb_sensor_scheduler.sv
module tb_sensor_scheduler;

    localparam int TMO = 100;
    localparam int GAP = 20;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic        continuo;
    logic [2:0]  mascara;
    logic        med_pronto;
    logic [11:0] med_valor;
    logic        med_start;
    logic [1:0]  sel_sensor;
    logic [11:0] distancia1;
    logic [11:0] distancia2;
    logic [11:0] distancia3;
    logic [2:0]  valido;
    logic [2:0]  erro_timeout;
    logic        varredura_fim;
    logic        ocupado;
    logic [3:0]  db_estado;
    logic [3:0]  db_sensor;

    sensor_scheduler #(
        .MEDIDA_W      (12),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .continuo     (continuo),
        .mascara      (mascara),
        .med_pronto   (med_pronto),
        .med_valor    (med_valor),
        .med_start    (med_start),
        .sel_sensor   (sel_sensor),
        .distancia1   (distancia1),
        .distancia2   (distancia2),
        .distancia3   (distancia3),
        .valido       (valido),
        .erro_timeout (erro_timeout),
        .varredura_fim(varredura_fim),
        .ocupado      (ocupado),
        .db_estado    (db_estado),
        .db_sensor    (db_sensor)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-sensor behaviour of the shared-unit model: answer delay (0 = silent)
    int          dly[3];
    logic [11:0] val[3];

    // Observed events and expected events
    int st_cyc[$];
    int st_sel[$];
    int st_db[$];
    int fim_cyc[$];
    int ex_cyc[$];
    int ex_sel[$];
    int ex_fim[$];

    // Reference state of the per-sensor results
    logic [11:0] md_dist[3];
    logic [2:0]  md_v;
    logic [2:0]  md_e;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (med_start === 1'b1) begin
                st_cyc.push_back(cyc);
                st_sel.push_back(int'(sel_sensor));
                st_db.push_back(int'(db_sensor));
            end
            if (varredura_fim === 1'b1) fim_cyc.push_back(cyc);
        end
    end

    // Shared measurement unit model: answers dly[sel] cycles after med_start
    initial begin : responder
        int rs;
        int rd;
        med_pronto = 1'b0;
        med_valor  = 12'h000;
        forever begin
            @(negedge clock);
            if (med_start === 1'b1) begin
                rs = int'(sel_sensor);
                rd = dly[rs];
                if (rd > 0) begin
                    repeat (rd) @(negedge clock);
                    med_valor  = val[rs];
                    med_pronto = 1'b1;
                    @(negedge clock);
                    med_pronto = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected schedule of one sweep whose iniciar edge (or FIM-1) is cycle c0.
    // Returns the cycle of the varredura_fim pulse.
    function automatic int build_sweep(input int c0, input logic [2:0] m);
        int t;
        t = c0 + 3;
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                ex_cyc.push_back(t);
                ex_sel.push_back(i);
                if (dly[i] >= 1 && dly[i] <= TMO) begin
                    md_dist[i] = val[i];
                    md_v[i]    = 1'b1;
                    md_e[i]    = 1'b0;
                    t = t + dly[i] + GAP + 2;
                end else begin
                    md_v[i] = 1'b0;
                    md_e[i] = 1'b1;
                    t = t + TMO + GAP + 2;
                end
            end
        end
        ex_fim.push_back(t);
        return t;
    endfunction

    task automatic clear_q();
        st_cyc.delete(); st_sel.delete(); st_db.delete(); fim_cyc.delete();
        ex_cyc.delete(); ex_sel.delete(); ex_fim.delete();
    endtask

    task automatic start_sweep(output int c0);
        @(negedge clock);
        iniciar = 1'b1;
        c0 = cyc;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (fim_cyc.size() < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        repeat (40) @(negedge clock);
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_nstart"}, st_cyc.size(), ex_cyc.size());
        for (int i = 0; i < st_cyc.size() && i < ex_cyc.size(); i++) begin
            chk({tag, "_start_cyc"}, st_cyc[i], ex_cyc[i]);
            chk({tag, "_start_sel"}, st_sel[i], ex_sel[i]);
            chk({tag, "_db_sensor"}, st_db[i], ex_sel[i] + 1);
        end
        chk({tag, "_nfim"}, fim_cyc.size(), ex_fim.size());
        for (int i = 0; i < fim_cyc.size() && i < ex_fim.size(); i++) begin
            chk({tag, "_fim_cyc"}, fim_cyc[i], ex_fim[i]);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_dist1"}, distancia1, md_dist[0]);
        chk({tag, "_dist2"}, distancia2, md_dist[1]);
        chk({tag, "_dist3"}, distancia3, md_dist[2]);
        chk({tag, "_valido"}, valido, md_v);
        chk({tag, "_erro"}, erro_timeout, md_e);
        chk({tag, "_idle_state"}, db_estado, 4'd0);
        chk({tag, "_idle_ocupado"}, ocupado, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_med_start"}, med_start, 1'b0);
        chk({tag, "_sel"}, sel_sensor, 2'd0);
        chk({tag, "_dist1"}, distancia1, 12'h000);
        chk({tag, "_dist2"}, distancia2, 12'h000);
        chk({tag, "_dist3"}, distancia3, 12'h000);
        chk({tag, "_valido"}, valido, 3'b000);
        chk({tag, "_erro"}, erro_timeout, 3'b000);
        chk({tag, "_fim"}, varredura_fim, 1'b0);
        chk({tag, "_ocupado"}, ocupado, 1'b0);
        chk({tag, "_state"}, db_estado, 4'd0);
        chk({tag, "_db_sensor"}, db_sensor, 4'd0);
    endtask

    task automatic run_sweep(input string tag, input logic [2:0] m);
        int c0;
        int f;
        clear_q();
        mascara = m;
        start_sweep(c0);
        f = build_sweep(c0, m);
        wait_done(1);
        check_events(tag);
        check_outputs(tag);
    endtask

    initial begin : main
        int c0;
        int f1;
        int f2;
        int ch;
        reset    = 1'b0;
        iniciar  = 1'b0;
        continuo = 1'b0;
        mascara  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dly[i] = 10; val[i] = 12'h000; md_dist[i] = 12'h000;
        end
        md_v = 3'b000;
        md_e = 3'b000;

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // All three sensors answer after 10 cycles
        val[0] = 12'h123; val[1] = 12'h045; val[2] = 12'h300;
        run_sweep("t1", 3'b111);

        // Sensor 2 silent -> timeout, its distance is kept
        dly[1] = 0;
        val[0] = 12'h111; val[1] = 12'h999; val[2] = 12'h222;
        run_sweep("t2", 3'b111);
        dly[1] = 10;

        // Partial and empty masks
        val[0] = 12'h0a5; val[2] = 12'h5a0;
        run_sweep("t3_101", 3'b101);
        run_sweep("t3_000", 3'b000);

        // Answer on the exact timeout cycle after a timeout; iniciar while busy
        dly[0] = 0;
        run_sweep("t6_pre", 3'b001);
        dly[0] = TMO;
        val[0] = 12'h777;
        clear_q();
        mascara = 3'b001;
        start_sweep(c0);
        f1 = build_sweep(c0, 3'b001);
        repeat (20) @(negedge clock);
        iniciar = 1'b1;
        chk("t6_busy", ocupado, 1'b1);
        @(negedge clock);
        iniciar = 1'b0;
        wait_done(1);
        check_events("t6");
        check_outputs("t6");
        dly[0] = 10;

        // Continuous mode: mask change applies at the next PREPARA, then stop
        clear_q();
        continuo = 1'b1;
        mascara  = 3'b001;
        val[0] = 12'h314; val[2] = 12'h159;
        start_sweep(c0);
        f1 = build_sweep(c0, 3'b001);
        f2 = build_sweep(f1 - 1, 3'b100);
        repeat (5) @(negedge clock);
        mascara = 3'b100;
        while (cyc < f1 + 1) @(negedge clock);
        chk("t4_prepara_after_fim", db_estado, 4'd1);
        while (cyc < f1 + 3) @(negedge clock);
        continuo = 1'b0;
        wait_done(2);
        check_events("t4");
        check_outputs("t4");

        // Randomized sweeps
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) begin
                ch = int'($urandom_range(0, 4));
                case (ch)
                    0:       dly[i] = 0;
                    1:       dly[i] = TMO;
                    2:       dly[i] = TMO + 1;
                    default: dly[i] = int'($urandom_range(1, TMO - 1));
                endcase
                val[i] = 12'($urandom_range(0, 4095));
            end
            run_sweep("rnd", 3'($urandom_range(0, 7)));
        end

        // Reset in ESPERA; late answer and held iniciar must start nothing
        for (int i = 0; i < 3; i++) dly[i] = 10;
        val[0] = 12'hfed;
        run_sweep("t5_pre", 3'b001);
        clear_q();
        dly[0] = 50;
        mascara = 3'b001;
        start_sweep(c0);
        while (cyc < c0 + 23) @(negedge clock);
        chk("t5_in_espera", db_estado, 4'd3);
        #2 reset = 1'b0;
        #1 check_all_zero("t5_async");
        iniciar = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) md_dist[i] = 12'h000;
        md_v = 3'b000;
        md_e = 3'b000;
        clear_q();
        repeat (80) @(negedge clock);
        chk("t5_no_start", st_cyc.size(), 0);
        chk("t5_no_fim", fim_cyc.size(), 0);
        chk("t5_idle", db_estado, 4'd0);
        chk("t5_valido", valido, 3'b000);
        chk("t5_dist1", distancia1, 12'h000);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
        dly[0] = 10; dly[1] = 0;
        val[0] = 12'h246; val[1] = 12'h135;
        run_sweep("t5_after", 3'b011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
